// File: rtl/i2c_slave_serial_if.sv
// ----------------------------------------------------------------------------
// i2c_slave_serial_if
// Bit/byte-level I2C slave front end feeding a register file. SCL/SDA are
// synchronised and deglitched, START/STOP are detected, the 7-bit device
// address is matched, and bus bytes become register-file accesses. The block
// owns the register pointer, which auto-increments on every data byte.
//
// Ports:
//   clk          system clock (>= 16x SCL)
//   rst          synchronous, active-high reset
//   scl_in       raw SCL from pad
//   sda_in       raw SDA from pad
//   sda_oe       1 = pull SDA low, 0 = release (open drain)
//   regAddr      register pointer to register file
//   dataToReg    write data to register file
//   writeEn      one-clk write strobe
//   dataFromReg  read data, valid one clk after regAddr changes
//   busy         high from address-match ACK until STOP/START/NACK
// ----------------------------------------------------------------------------
module i2c_slave_serial_if #(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         DEB_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] regAddr,
    output logic [7:0] dataToReg,
    output logic       writeEn,
    input  logic [7:0] dataFromReg,
    output logic       busy
);

    localparam int CW = $clog2(DEB_LEN) + 1;

    typedef enum logic [3:0] {
        IDLE, DEVADDR, ACK_DEV, REGADDR, ACK_REG,
        WRDATA, ACK_WR, RDDATA, RD_MACK, WAIT_STOP
    } state_t;

    // Bit 1 carries SCL, bit 0 carries SDA throughout the input path.
    logic [1:0]         r_sync1, r_sync2, r_filt, r_filt_d;
    logic [1:0][CW-1:0] r_deb_cnt;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_shift;
    logic [3:0]  r_bit_cnt;
    logic        r_mack_ok;

    logic w_scl_f, w_sda_f, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic w_byte_done, w_addr_match;

    // ------------------------------------------------------------------
    // Input path: 2-flop sync, then a line only changes after DEB_LEN
    // consecutive synchronised samples disagree with its filtered value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 2'b11;
            r_sync2   <= 2'b11;
            r_filt    <= 2'b11;
            r_filt_d  <= 2'b11;
            r_deb_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            r_sync1  <= {scl_in, sda_in};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == CW'(DEB_LEN - 1)) begin
                    r_filt[i]    <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_scl_f      = r_filt[1];
    assign w_sda_f      = r_filt[0];
    assign w_scl_rise   = r_filt[1] & ~r_filt_d[1];
    assign w_scl_fall   = ~r_filt[1] & r_filt_d[1];
    // SDA edges only count as START/STOP when SCL was high on both samples.
    assign w_start      = r_filt[1] & r_filt_d[1] & r_filt_d[0] & ~r_filt[0];
    assign w_stop       = r_filt[1] & r_filt_d[1] & ~r_filt_d[0] & r_filt[0];
    assign w_byte_done  = (r_bit_cnt == 4'd8);
    assign w_addr_match = (r_shift[7:1] == DEV_ADDR);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state. START/STOP override every state.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so no path through this block infers a latch.
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = IDLE;
        end else if (w_start) begin
            w_state_nxt = DEVADDR;
        end else begin
            case (r_state)
                DEVADDR:   if (w_scl_fall && w_byte_done)
                               w_state_nxt = w_addr_match ? ACK_DEV : WAIT_STOP;
                ACK_DEV:   if (w_scl_fall) w_state_nxt = r_shift[0] ? RDDATA : REGADDR;
                REGADDR:   if (w_scl_fall && w_byte_done) w_state_nxt = ACK_REG;
                ACK_REG:   if (w_scl_fall) w_state_nxt = WRDATA;
                WRDATA:    if (w_scl_fall && w_byte_done) w_state_nxt = ACK_WR;
                ACK_WR:    if (w_scl_fall) w_state_nxt = WRDATA;
                RDDATA:    if (w_scl_fall && w_byte_done) w_state_nxt = RD_MACK;
                RD_MACK: begin
                    if (w_scl_rise && w_sda_f)        w_state_nxt = WAIT_STOP;
                    else if (w_scl_fall && r_mack_ok) w_state_nxt = RDDATA;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        case (r_state)
            ACK_DEV, REGADDR, ACK_REG, WRDATA, ACK_WR, RDDATA, RD_MACK: busy = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, bit counter, pointer, SDA drive.
    // Bits are sampled on filtered SCL rise; SDA only changes on its fall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_mack_ok <= 1'b0;
            sda_oe    <= 1'b0;
            regAddr   <= '0;
            dataToReg <= '0;
            writeEn   <= 1'b0;
        end else begin
            writeEn <= 1'b0;
            // Post-increment lands the clk after the strobe so the register
            // file sees the address the byte was meant for.
            if (writeEn) regAddr <= regAddr + 8'd1;

            if (w_stop || w_start) begin
                // Any partial byte is dropped; the pointer survives Sr.
                sda_oe    <= 1'b0;
                r_bit_cnt <= '0;
                r_mack_ok <= 1'b0;
            end else begin
                case (r_state)
                    DEVADDR, REGADDR, WRDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda_f};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && w_byte_done) begin
                            r_bit_cnt <= '0;
                            sda_oe    <= 1'b1;
                            if (r_state == DEVADDR) sda_oe <= w_addr_match;
                            if (r_state == REGADDR) regAddr <= r_shift;
                            if (r_state == WRDATA) begin
                                writeEn   <= 1'b1;
                                dataToReg <= r_shift;
                            end
                        end
                    end
                    ACK_DEV: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= '0;
                            if (r_shift[0]) begin
                                r_shift <= dataFromReg;
                                sda_oe  <= ~dataFromReg[7];
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ACK_REG, ACK_WR: begin
                        if (w_scl_fall) begin
                            sda_oe    <= 1'b0;
                            r_bit_cnt <= '0;
                        end
                    end
                    RDDATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (w_byte_done) begin
                                sda_oe    <= 1'b0;
                                r_bit_cnt <= '0;
                            end else begin
                                r_shift <= {r_shift[6:0], 1'b0};
                                sda_oe  <= ~r_shift[6];
                            end
                        end
                    end
                    RD_MACK: begin
                        // Pointer advances at the ACK rise; the half SCL period
                        // before the fall covers the register-file read latency.
                        if (w_scl_rise && !w_sda_f) begin
                            r_mack_ok <= 1'b1;
                            regAddr   <= regAddr + 8'd1;
                        end else if (w_scl_fall && r_mack_ok) begin
                            r_mack_ok <= 1'b0;
                            r_shift   <= dataFromReg;
                            sda_oe    <= ~dataFromReg[7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
